// File: rtl/dram_line_arbiter_pkg.sv
// Shared constants and state encoding for the line RAM arbiter and its
// round-robin helper.
package dram_line_arbiter_pkg;

  localparam int LINE_BITS     = 256;
  localparam int LINE_OFS_BITS = 5;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dram_line_arbiter_rr_arb2.sv
// Two-way round-robin grant: a sole requester wins, a tie goes to the port
// that was not granted last. Purely combinational.
module rr_arb2
  import dram_line_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/dram_line_arbiter.sv
// Shares the line data RAM between the I-cache (port 0) and D-cache (port 1):
// one transaction in flight, round-robin grant, LAT RAM cycles per access.
module dram_line_arbiter
  import dram_line_arbiter_pkg::*;
#(
  parameter int LAT    = 2,
  parameter int ADDR_W = 32,
  parameter int LINE_W = LINE_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LINE_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LINE_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp0_valid,
  output logic [LINE_W-1:0] resp0_rdata,
  output logic              resp1_valid,
  output logic [LINE_W-1:0] resp1_rdata,
  output logic              ram_read_op,
  output logic              ram_write_op,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [LINE_W-1:0] ram_wdata,
  input  logic [LINE_W-1:0] ram_rdata
);

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  arb_state_t        state;
  logic [3:0]        cnt;
  logic              last_grant;
  logic              owner;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  logic [LINE_W-1:0] rdata_q;
  logic              resp0_q;
  logic              resp1_q;
  logic [1:0]        gnt;
  logic              is_idle;
  logic              in_wait;
  logic              last_cycle;
  logic [ADDR_W-1:0] sel_addr;
  logic              unused_ofs;

  rr_arb2 u_rr_arb2 (
    .req  ({req1_valid, req0_valid}),
    .last (last_grant),
    .gnt  (gnt)
  );

  assign is_idle    = (state == ARB_IDLE);
  assign in_wait    = (state == ARB_WAIT);
  assign last_cycle = in_wait && (cnt == 4'd0);
  assign sel_addr   = gnt[1] ? req1_addr : req0_addr;
  assign unused_ofs = ^{req0_addr[LINE_OFS_BITS-1:0], req1_addr[LINE_OFS_BITS-1:0]};

  assign req0_ready = is_idle & gnt[0];
  assign req1_ready = is_idle & gnt[1];

  // Reads hold read_op for the whole access; writes strobe only on the final cycle.
  assign ram_read_op  = in_wait & ~lat_we;
  assign ram_write_op = last_cycle & lat_we;
  assign ram_addr     = in_wait ? lat_addr : '0;
  assign ram_wdata    = (in_wait && lat_we) ? lat_wdata : '0;

  assign resp0_valid = resp0_q;
  assign resp1_valid = resp1_q;
  assign resp0_rdata = (resp0_q && !lat_we) ? rdata_q : '0;
  assign resp1_rdata = (resp1_q && !lat_we) ? rdata_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      resp0_q    <= 1'b0;
      resp1_q    <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|gnt) begin
            owner      <= gnt[1];
            last_grant <= gnt[1];
            lat_we     <= gnt[1] ? req1_we : req0_we;
            lat_addr   <= {sel_addr[ADDR_W-1:LINE_OFS_BITS], {LINE_OFS_BITS{1'b0}}};
            cnt        <= LAT_M1;
            state      <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (cnt == 4'd0) begin
            resp0_q <= ~owner;
            resp1_q <= owner;
            state   <= ARB_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ARB_RESP: begin
          resp0_q <= 1'b0;
          resp1_q <= 1'b0;
          state   <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Line registers carry no reset; every output path through them is gated by state.
  always_ff @(posedge clk) begin
    if (is_idle && (|gnt)) lat_wdata <= gnt[1] ? req1_wdata : req0_wdata;
    if (last_cycle && !lat_we) rdata_q <= ram_rdata;
  end

endmodule

// File: tb/tb_dram_line_arbiter.sv
// Self-checking bench: three arbiters (LAT=2,3,1) each with a private line RAM,
// directed corner cases, a grant table, and random traffic against a schedule model.
module tb_dram_line_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]   rst_v = 3'b111;
  logic [2:0]   v0 = '0, v1 = '0, we0 = '0, we1 = '0;
  logic [31:0]  a0 [3];
  logic [31:0]  a1 [3];
  logic [255:0] wd0 [3];
  logic [255:0] wd1 [3];
  logic [2:0]   rdy0, rdy1, rv0, rv1, rop, wop;
  logic [255:0] rd0 [3];
  logic [255:0] rd1 [3];
  logic [255:0] rwd [3];
  logic [255:0] rrd [3];
  logic [31:0]  radr [3];
  logic [255:0] mem [3][16];
  logic         init_mem = 1'b1;
  logic         mon_en = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 3 : 1);
  endfunction

  function automatic logic [255:0] init_line(input int k, input int i);
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[32*w +: 32] = 32'((k + 1) * 32'h1000_0000 + i * 16 + w);
    return r;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int L = (k == 0) ? 2 : ((k == 1) ? 3 : 1);
    dram_line_arbiter #(.LAT(L), .ADDR_W(32), .LINE_W(256)) dut (
      .clk          (clk),
      .rst          (rst_v[k]),
      .req0_valid   (v0[k]),
      .req0_we      (we0[k]),
      .req0_addr    (a0[k]),
      .req0_wdata   (wd0[k]),
      .req0_ready   (rdy0[k]),
      .req1_valid   (v1[k]),
      .req1_we      (we1[k]),
      .req1_addr    (a1[k]),
      .req1_wdata   (wd1[k]),
      .req1_ready   (rdy1[k]),
      .resp0_valid  (rv0[k]),
      .resp0_rdata  (rd0[k]),
      .resp1_valid  (rv1[k]),
      .resp1_rdata  (rd1[k]),
      .ram_read_op  (rop[k]),
      .ram_write_op (wop[k]),
      .ram_addr     (radr[k]),
      .ram_wdata    (rwd[k]),
      .ram_rdata    (rrd[k])
    );
    assign rrd[k] = mem[k][radr[k][8:5]];
  end

  // Behavioural line RAM: combinational read, write on the clock edge.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (init_mem) begin
        for (int i = 0; i < 16; i++) mem[k][i] <= init_line(k, i);
      end else if (wop[k]) begin
        mem[k][radr[k][8:5]] <= rwd[k];
      end
    end
  end

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Schedule model: phase counts down from LAT+1 after an accept; phase 1 is the
  // response cycle, phases LAT+1..2 are RAM access cycles.
  int           phase [3];
  logic         mlast [3];
  logic         mown [3];
  logic         mwe [3];
  logic [31:0]  madr [3];
  logic [255:0] mwd [3];
  logic [255:0] exp_mem [3][16];

  task automatic model_cycle(input int k);
    logic g, e_r0, e_r1, e_v0, e_v1, e_rd, e_wr;
    logic [31:0] e_addr;
    logic [255:0] e_wd, e_d0, e_d1, line;
    int p;
    p = phase[k];
    g = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0; e_v0 = 1'b0; e_v1 = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
    e_addr = '0; e_wd = '0; e_d0 = '0; e_d1 = '0;
    if (p == 0) begin
      if (v0[k] || v1[k]) begin
        g = (v0[k] && v1[k]) ? ~mlast[k] : v1[k];
        e_r0 = ~g;
        e_r1 = g;
      end
    end else if (p == 1) begin
      e_v0 = ~mown[k];
      e_v1 = mown[k];
      line = mwe[k] ? '0 : exp_mem[k][madr[k][8:5]];
      if (mown[k]) e_d1 = line; else e_d0 = line;
    end else begin
      e_rd = ~mwe[k];
      e_wr = mwe[k] && (p == 2);
      e_addr = madr[k];
      e_wd = mwe[k] ? mwd[k] : '0;
    end
    check($sformatf("mon%0d ctl", k), 256'({rdy0[k], rdy1[k], rv0[k], rv1[k], rop[k], wop[k]}),
          256'({e_r0, e_r1, e_v0, e_v1, e_rd, e_wr}));
    check($sformatf("mon%0d addr", k), 256'(radr[k]), 256'(e_addr));
    check($sformatf("mon%0d wdata", k), rwd[k], e_wd);
    check($sformatf("mon%0d rdata0", k), rd0[k], e_d0);
    check($sformatf("mon%0d rdata1", k), rd1[k], e_d1);
    if (e_wr) exp_mem[k][madr[k][8:5]] = mwd[k];
    if (rst_v[k]) begin
      phase[k] = 0;
      mlast[k] = 1'b1;
    end else if (p == 0) begin
      if (v0[k] || v1[k]) begin
        mown[k]  = g;
        mlast[k] = g;
        mwe[k]   = g ? we1[k] : we0[k];
        madr[k]  = (g ? a1[k] : a0[k]) & ~32'h1F;
        mwd[k]   = g ? wd1[k] : wd0[k];
        phase[k] = lat_of(k) + 1;
      end
    end else begin
      phase[k] = p - 1;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      phase[k] = 0; mlast[k] = 1'b1; mown[k] = 1'b0; mwe[k] = 1'b0; madr[k] = '0; mwd[k] = '0;
      for (int i = 0; i < 16; i++) exp_mem[k][i] = init_line(k, i);
    end
    forever begin
      @(negedge clk);
      if (mon_en) for (int k = 0; k < 3; k++) model_cycle(k);
    end
  end

  typedef struct {
    logic rst;
    logic v0;
    logic v1;
    logic r0;
    logic r1;
  } vec_t;

  vec_t tbl [10];

  task automatic do_reset(input int k);
    rst_v[k] = 1'b1;
    v0[k] = 1'b0;
    v1[k] = 1'b0;
    nxt();
    nxt();
    rst_v[k] = 1'b0;
  endtask

  task automatic check_output(input vec_t v);
    @(negedge clk);
    check("table ready", 256'({rdy0[0], rdy1[0]}), 256'({v.r0, v.r1}));
  endtask

  task automatic apply_stimulus(input vec_t v);
    if (v.rst) do_reset(0);
    v0[0] = v.v0; v1[0] = v.v1; we0[0] = 1'b0; we1[0] = 1'b0;
    a0[0] = $urandom; a1[0] = $urandom;
    check_output(v);
    nxt();
    v0[0] = 1'b0; v1[0] = 1'b0;
    if (v.r0 || v.r1) repeat (3) nxt();
  endtask

  task automatic new_req(input int k, input int p);
    if (p == 0) begin
      we0[k] = 1'($urandom); a0[k] = $urandom; wd0[k] = rand_line();
    end else begin
      we1[k] = 1'($urandom); a1[k] = $urandom; wd1[k] = rand_line();
    end
  endtask

  task automatic drive_port(input int k, input int p, input logic acc);
    logic val;
    val = (p == 0) ? v0[k] : v1[k];
    if (acc || !val) begin
      val = ($urandom_range(0, 2) != 0);
      new_req(k, p);
    end else if ($urandom_range(0, 19) == 0) begin
      val = 1'b0;
    end
    if (p == 0) v0[k] = val; else v1[k] = val;
  endtask

  logic [255:0] pat, saved;
  logic [2:0]   acc0, acc1;
  int n0, n1, nw, last_t, ng;
  logic exp_g;

  initial begin
    for (int k = 0; k < 3; k++) begin
      a0[k] = '0; a1[k] = '0; wd0[k] = '0; wd1[k] = '0;
    end
    nxt();
    init_mem = 1'b0;
    nxt();
    mon_en = 1'b1;
    nxt();
    rst_v = 3'b000;

    // Reset state and a plain LAT=2 read of line 0x40.
    @(negedge clk);
    check("reset outputs", 256'({rdy0[0], rdy1[0], rv0[0], rv1[0], rop[0], wop[0]}), 256'(0));
    nxt();
    v0[0] = 1'b1; we0[0] = 1'b0; a0[0] = 32'h40;
    @(negedge clk); check("t1 ready0", 256'(rdy0[0]), 256'(1));
    nxt(); v0[0] = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check("t1 read_op", 256'(rop[0]), 256'(1));
      check("t1 ram_addr", 256'(radr[0]), 256'(32'h40));
      nxt();
    end
    @(negedge clk);
    check("t1 resp0_valid", 256'(rv0[0]), 256'(1));
    check("t1 resp0_rdata", rd0[0], init_line(0, 2));
    nxt();

    // Port 1 write to unaligned 0x2F, then read back through port 0.
    for (int b = 0; b < 32; b++) pat[8*b +: 8] = 8'(b + 1);
    v1[0] = 1'b1; we1[0] = 1'b1; a1[0] = 32'h2F; wd1[0] = pat;
    @(negedge clk); check("t2 ready1", 256'(rdy1[0]), 256'(1));
    nxt(); v1[0] = 1'b0;
    nw = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      nw += int'(wop[0]);
      if (c < 3) check("t2 ram_addr", 256'(radr[0]), 256'(32'h20));
      if (c == 3) check("t2 resp1", 256'({rv1[0], rv0[0]}), 256'(2'b10));
      nxt();
    end
    check("t2 write pulses", 256'(nw), 256'(1));
    v0[0] = 1'b1; we0[0] = 1'b0; a0[0] = 32'h20;
    @(negedge clk); check("t2 ready0", 256'(rdy0[0]), 256'(1));
    nxt(); v0[0] = 1'b0;
    nxt(); nxt();
    @(negedge clk);
    check("t2 readback", rd0[0], pat);
    nxt();

    // Request arriving mid-transaction waits for IDLE, then completes once.
    do_reset(0);
    v1[0] = 1'b1; we1[0] = 1'b0; a1[0] = 32'h80;
    @(negedge clk); check("t4 ready1", 256'(rdy1[0]), 256'(1));
    nxt(); v1[0] = 1'b0; v0[0] = 1'b1; we0[0] = 1'b0; a0[0] = 32'hA0;
    n0 = 0; n1 = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c <= 3) check("t4 ready0 held", 256'(rdy0[0]), 256'(0));
      if (c == 4) check("t4 ready0 idle", 256'(rdy0[0]), 256'(1));
      n0 += int'(rv0[0]);
      n1 += int'(rv1[0]);
      nxt();
      if (c == 4) v0[0] = 1'b0;
    end
    check("t4 resp0 count", 256'(n0), 256'(1));
    check("t4 resp1 count", 256'(n1), 256'(1));

    // Grant table.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) apply_stimulus(tbl[i]);

    // Continuous contention: alternate 0,1,0,1 every LAT+2 cycles.
    do_reset(0);
    v0[0] = 1'b1; v1[0] = 1'b1; new_req(0, 0); new_req(0, 1);
    last_t = -1; exp_g = 1'b0; ng = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      acc0[0] = rdy0[0]; acc1[0] = rdy1[0];
      if (rdy0[0] || rdy1[0]) begin
        check("t3 grant", 256'({rdy0[0], rdy1[0]}), 256'({~exp_g, exp_g}));
        if (last_t >= 0) check("t3 spacing", 256'(c - last_t), 256'(lat_of(0) + 2));
        last_t = c; exp_g = ~exp_g; ng++;
      end
      nxt();
      if (acc0[0]) new_req(0, 0);
      if (acc1[0]) new_req(0, 1);
    end
    v0[0] = 1'b0; v1[0] = 1'b0;
    check("t3 grant count", 256'(ng), 256'(10));

    // LAT=3: reset with one access cycle left aborts the write.
    do_reset(1);
    saved = mem[1][3];
    v1[1] = 1'b1; we1[1] = 1'b1; a1[1] = 32'h60; wd1[1] = ~saved;
    @(negedge clk); check("t5 ready1", 256'(rdy1[1]), 256'(1));
    nxt(); v1[1] = 1'b0;
    @(negedge clk); check("t5 no write c1", 256'(wop[1]), 256'(0));
    nxt(); rst_v[1] = 1'b1;
    @(negedge clk); check("t5 no write c2", 256'(wop[1]), 256'(0));
    nxt(); rst_v[1] = 1'b0;
    v0[1] = 1'b1; v1[1] = 1'b1; we0[1] = 1'b0; we1[1] = 1'b0;
    @(negedge clk);
    check("t5 no resp", 256'({rv0[1], rv1[1]}), 256'(0));
    check("t5 line kept", mem[1][3], saved);
    check("t5 tie to port0", 256'({rdy0[1], rdy1[1]}), 256'(2'b10));
    nxt(); v0[1] = 1'b0; v1[1] = 1'b0;
    repeat (5) nxt();

    // LAT=1: single access cycle, response two cycles after accept.
    do_reset(2);
    v0[2] = 1'b1; we0[2] = 1'b0; a0[2] = 32'h100;
    @(negedge clk); check("t6 ready0", 256'(rdy0[2]), 256'(1));
    nxt(); v0[2] = 1'b0;
    @(negedge clk);
    check("t6 read_op", 256'({rop[2], rv0[2]}), 256'(2'b10));
    nxt();
    @(negedge clk);
    check("t6 resp", 256'({rop[2], rv0[2]}), 256'(2'b01));
    check("t6 rdata", rd0[2], init_line(2, 8));
    nxt();

    // Random traffic on all three instances, including stray resets.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        acc0[k] = v0[k] & rdy0[k] & ~rst_v[k];
        acc1[k] = v1[k] & rdy1[k] & ~rst_v[k];
      end
      nxt();
      for (int k = 0; k < 3; k++) begin
        rst_v[k] = ($urandom_range(0, 39) == 0);
        drive_port(k, 0, acc0[k]);
        drive_port(k, 1, acc1[k]);
      end
    end
    rst_v = 3'b000; v0 = '0; v1 = '0;
    repeat (20) nxt();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
